// File: rtl/multdiv_unit.sv
// Iterative signed 32x32 multiply (radix-2 Booth) / divide (non-restoring); optional divider via MULTDIV_DIV_EN.
// Latency: result and 1-cycle data_resultRDY 33 edges after start; divide-by-zero (or any divide with divider absent) after 1 edge.
// Backpressure: none; ctrl_busy tells the pipeline to stall, starts are ignored outside IDLE and never queued.
module multdiv_unit (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic [4:0]  ctrl_destReg,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        ctrl_busy,
    output logic [4:0]  out_writeReg
);

    typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    // Booth product register: [64:33] accumulator, [32:1] multiplier Q, [0] q-1
    logic [64:0] prod_q, prod_d;
    logic [31:0] mcand_q, mcand_d;
    logic [4:0]  tag_q, tag_d;
    // Forced result 0 with exception (divide by zero, or divider absent)
    logic        dz_q, dz_d;
    logic [32:0] booth_sum;

    logic [31:0] res_q, res_d;
    logic        exc_q, exc_d;
    logic        rdy_q, rdy_d;
    logic        busy_q, busy_d;
    logic [4:0]  wr_q, wr_d;

`ifdef MULTDIV_DIV_EN
    // Partial remainder is kept wide enough that shift-then-add never overflows
    logic [33:0] rem_q, rem_d;
    logic [33:0] rem_sh, rem_nx;
    logic [31:0] quot_q, quot_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic        neg_q, neg_d;
    logic        ovf_q, ovf_d;
    logic        is_div_q, is_div_d;
    logic [31:0] a_mag, b_mag;

    assign a_mag = data_operandA[31] ? (32'd0 - data_operandA) : data_operandA;
    assign b_mag = data_operandB[31] ? (32'd0 - data_operandB) : data_operandB;
`endif

    // Next-state, datapath iteration and output-register computation
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prod_d    = prod_q;
        mcand_d   = mcand_q;
        tag_d     = tag_q;
        dz_d      = dz_q;
        res_d     = res_q;
        exc_d     = exc_q;
        rdy_d     = 1'b0;
        wr_d      = wr_q;
        booth_sum = {prod_q[64], prod_q[64:33]};
`ifdef MULTDIV_DIV_EN
        rem_d     = rem_q;
        quot_d    = quot_q;
        dvsr_d    = dvsr_q;
        neg_d     = neg_q;
        ovf_d     = ovf_q;
        is_div_d  = is_div_q;
        rem_sh    = {rem_q[32:0], quot_q[31]};
        rem_nx    = rem_q[33] ? (rem_sh + {2'b00, dvsr_q}) : (rem_sh - {2'b00, dvsr_q});
`endif
        case (state_q)
            IDLE: begin
                if (ctrl_MULT) begin
                    state_d = MULT;
                    cnt_d   = 6'd0;
                    prod_d  = {32'd0, data_operandB, 1'b0};
                    mcand_d = data_operandA;
                    tag_d   = ctrl_destReg;
                    dz_d    = 1'b0;
`ifdef MULTDIV_DIV_EN
                    is_div_d = 1'b0;
`endif
                end else if (ctrl_DIV) begin
                    tag_d = ctrl_destReg;
                    cnt_d = 6'd0;
`ifdef MULTDIV_DIV_EN
                    is_div_d = 1'b1;
                    if (data_operandB == 32'd0) begin
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        dz_d    = 1'b0;
                        state_d = DIV;
                        rem_d   = 34'd0;
                        quot_d  = a_mag;
                        dvsr_d  = b_mag;
                        neg_d   = data_operandA[31] ^ data_operandB[31];
                        ovf_d   = (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
                    end
`else
                    dz_d    = 1'b1;
                    state_d = DONE;
`endif
                end
            end
            MULT: begin
                case (prod_q[1:0])
                    2'b01:   booth_sum = {prod_q[64], prod_q[64:33]} + {mcand_q[31], mcand_q};
                    2'b10:   booth_sum = {prod_q[64], prod_q[64:33]} - {mcand_q[31], mcand_q};
                    default: booth_sum = {prod_q[64], prod_q[64:33]};
                endcase
                // Arithmetic shift right of {sum, Q, q-1}; the 33rd sum bit becomes the new sign
                prod_d = {booth_sum, prod_q[32:1]};
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = DONE;
            end
`ifdef MULTDIV_DIV_EN
            DIV: begin
                rem_d  = rem_nx;
                quot_d = {quot_q[30:0], ~rem_nx[33]};
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'd31) state_d = DONE;
            end
`endif
            DONE: begin
                state_d = IDLE;
                rdy_d   = 1'b1;
                wr_d    = tag_q;
                if (dz_q) begin
                    res_d = 32'd0;
                    exc_d = 1'b1;
`ifdef MULTDIV_DIV_EN
                end else if (is_div_q) begin
                    res_d = neg_q ? (32'd0 - quot_q) : quot_q;
                    exc_d = ovf_q;
`endif
                end else begin
                    res_d = prod_q[32:1];
                    exc_d = (prod_q[64:33] != {32{prod_q[32]}});
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, datapath and output registers; reset aborts any operation silently
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            prod_q   <= 65'd0;
            mcand_q  <= 32'd0;
            tag_q    <= 5'd0;
            dz_q     <= 1'b0;
            res_q    <= 32'd0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
            wr_q     <= 5'd0;
`ifdef MULTDIV_DIV_EN
            rem_q    <= 34'd0;
            quot_q   <= 32'd0;
            dvsr_q   <= 32'd0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            is_div_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prod_q   <= prod_d;
            mcand_q  <= mcand_d;
            tag_q    <= tag_d;
            dz_q     <= dz_d;
            res_q    <= res_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
            wr_q     <= wr_d;
`ifdef MULTDIV_DIV_EN
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            dvsr_q   <= dvsr_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            is_div_q <= is_div_d;
`endif
        end
    end

    assign data_result    = res_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign ctrl_busy      = busy_q;
    assign out_writeReg   = wr_q;

endmodule

// File: tb/tb_multdiv_unit.sv
module tb_multdiv_unit;

    logic        clock = 1'b0;
    logic        ctrl_reset;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [4:0]  ctrl_destReg;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, ctrl_busy;
    logic [4:0]  out_writeReg;

    int checks   = 0;
    int failures = 0;

    multdiv_unit dut (
        .clock          (clock),
        .ctrl_reset     (ctrl_reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_destReg   (ctrl_destReg),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .ctrl_busy      (ctrl_busy),
        .out_writeReg   (out_writeReg)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit          is_div;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        logic [31:0] res;
        bit          exc;
        int          lat;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain signed arithmetic on the operation's meaning
    task automatic ref_model(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] res, output bit exc, output int lat);
        longint pa, pb, prod;
        int     q;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        if (!is_div) begin
            prod = pa * pb;
            res  = prod[31:0];
            exc  = (prod > 64'sd2147483647) || (prod < -64'sd2147483648);
            lat  = 33;
        end else begin
`ifdef MULTDIV_DIV_EN
            if (b == 32'd0) begin
                res = 32'd0; exc = 1'b1; lat = 1;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                res = 32'h8000_0000; exc = 1'b1; lat = 33;
            end else begin
                q   = $signed(a) / $signed(b);
                res = q; exc = 1'b0; lat = 33;
            end
`else
            res = 32'd0; exc = 1'b1; lat = 1;
`endif
        end
    endtask

    // Issue one operation at edge 0 and measure the edge at which the ready pulse appears
    task automatic run_op(input string name, input bit is_div, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag,
                          input logic [31:0] exp_res, input bit exp_exc, input int exp_lat);
        int lat;
        @(negedge clock);
        ctrl_MULT = !is_div; ctrl_DIV = is_div;
        data_operandA = a; data_operandB = b; ctrl_destReg = tag;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = $urandom; data_operandB = $urandom; ctrl_destReg = 5'($urandom);
        chk({name, " busy_after_start"}, ctrl_busy, 1);
        lat = 0;
        while (!data_resultRDY && lat < 100) begin
            @(posedge clock); #1;
            lat++;
        end
        chk({name, " latency"}, lat, exp_lat);
        chk({name, " result"}, data_result, exp_res);
        chk({name, " exception"}, data_exception, exp_exc);
        chk({name, " writeReg"}, out_writeReg, tag);
        chk({name, " busy_in_rdy"}, ctrl_busy, 0);
        @(posedge clock); #1;
        chk({name, " rdy_one_cycle"}, data_resultRDY, 0);
    endtask

    vec_t vecs[$];

    initial begin
        logic [31:0] r_res;
        bit          r_exc;
        int          r_lat;
        logic [31:0] held;
        int          rdy_seen;
        int          lat;

        ctrl_reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
        data_operandA = '0; data_operandB = '0; ctrl_destReg = '0;
        #2;
        chk("reset result", data_result, 0);
        chk("reset exception", data_exception, 0);
        chk("reset rdy", data_resultRDY, 0);
        chk("reset busy", ctrl_busy, 0);
        chk("reset writeReg", out_writeReg, 0);
        repeat (2) @(negedge clock);
        ctrl_reset = 1'b0;

        vecs.push_back('{0, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 1'b0, 33});
        vecs.push_back('{0, 32'h0001_0000,  32'h0001_0000, 5'd9,  32'h0000_0000, 1'b1, 33});
        vecs.push_back('{0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b0, 33});
        vecs.push_back('{0, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h0000_0000, 1'b1, 33});
        vecs.push_back('{0, 32'd6,          32'd7,         5'd2,  32'd42,        1'b0, 33});
`ifdef MULTDIV_DIV_EN
        vecs.push_back('{1, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 1'b0, 33});
        vecs.push_back('{1, 32'h8000_0000,  32'hFFFF_FFFF, 5'd12, 32'h8000_0000, 1'b1, 33});
        vecs.push_back('{1, 32'd100,        32'hFFFF_FFF9, 5'd4,  32'hFFFF_FFF2, 1'b0, 33});
        vecs.push_back('{1, 32'd10,         32'd2,         5'd3,  32'd5,         1'b0, 33});
`else
        vecs.push_back('{1, 32'd10,         32'd2,         5'd3,  32'd0,         1'b1, 1});
        vecs.push_back('{1, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'd0,         1'b1, 1});
`endif
        vecs.push_back('{1, 32'd5,          32'd0,         5'd8,  32'd0,         1'b1, 1});

        foreach (vecs[i])
            run_op($sformatf("vec%0d", i), vecs[i].is_div, vecs[i].a, vecs[i].b,
                   vecs[i].tag, vecs[i].res, vecs[i].exc, vecs[i].lat);

        // Previous result must stay held until the divide-by-zero completion edge
        run_op("pre_dz", 0, 32'd1000, 32'd3, 5'd6, 32'd3000, 0, 33);
        held = data_result;
        @(negedge clock);
        ctrl_DIV = 1'b1; data_operandA = 32'd5; data_operandB = 32'd0; ctrl_destReg = 5'd11;
        @(posedge clock); #1;
        ctrl_DIV = 1'b0;
        chk("dz held result", data_result, held);
        chk("dz rdy not yet", data_resultRDY, 0);
        @(posedge clock); #1;
        chk("dz rdy edge1", data_resultRDY, 1);
        chk("dz result", data_result, 0);
        chk("dz exception", data_exception, 1);
        chk("dz writeReg", out_writeReg, 11);
        @(posedge clock); #1;

        // ctrl_DIV pulsed at edge 10 of a MULT is ignored
        @(negedge clock);
        ctrl_MULT = 1'b1; data_operandA = 32'd123; data_operandB = 32'd456; ctrl_destReg = 5'd14;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        lat = 0;
        repeat (9) begin @(posedge clock); #1; lat++; end
        @(negedge clock);
        ctrl_DIV = 1'b1; data_operandA = 32'd5; data_operandB = 32'd0;
        @(posedge clock); #1; lat++;
        ctrl_DIV = 1'b0;
        while (!data_resultRDY && lat < 100) begin @(posedge clock); #1; lat++; end
        chk("ignore_div latency", lat, 33);
        chk("ignore_div result", data_result, 32'd56088);
        chk("ignore_div exception", data_exception, 0);
        chk("ignore_div writeReg", out_writeReg, 14);
        @(posedge clock); #1;

        // Reset at edge 15 of a MULT: outputs clear at once, no ready pulse follows
        @(negedge clock);
        ctrl_MULT = 1'b1; data_operandA = 32'd77; data_operandB = 32'd3; ctrl_destReg = 5'd21;
        @(posedge clock); #1;
        ctrl_MULT = 1'b0;
        repeat (14) @(posedge clock);
        @(negedge clock);
        ctrl_reset = 1'b1;
        #1;
        chk("midreset result", data_result, 0);
        chk("midreset writeReg", out_writeReg, 0);
        chk("midreset busy", ctrl_busy, 0);
        chk("midreset rdy", data_resultRDY, 0);
        chk("midreset exception", data_exception, 0);
        @(negedge clock);
        ctrl_reset = 1'b0;
        rdy_seen = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (data_resultRDY) rdy_seen++;
        end
        chk("midreset no rdy", rdy_seen, 0);
        run_op("after_reset", 0, 32'd6, 32'd7, 5'd3, 32'd42, 0, 33);

        // Randomized operations against the arithmetic reference
        for (int n = 0; n < 40; n++) begin
            bit          d;
            logic [31:0] a, b;
            logic [4:0]  t;
            d = 1'($urandom);
            a = $urandom;
            b = $urandom;
            t = 5'($urandom);
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: a = 32'h8000_0000;
                2: b = 32'hFFFF_FFFF;
                3: b = 32'($urandom_range(1, 9));
                4: a = 32'($signed(16'($urandom)));
                default: ;
            endcase
            ref_model(d, a, b, r_res, r_exc, r_lat);
            run_op($sformatf("rnd%0d", n), d, a, b, t, r_res, r_exc, r_lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
